// File: rtl/vickrey_scan_ctrl.sv
// vickrey_scan_ctrl: one sealed-bid second-price auction round over 2**N bidders.
// Sweeps the bid-select index once, tracking the highest bid, its index and the
// runner-up bid, then presents winner / win_bid / price until the next round.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; results from the last round are held
// ST_SCAN | one bidder per cycle, sel walks 0 .. 2**N-1
// ST_DONE | single-cycle done pulse, results valid, back to ST_IDLE
module vickrey_scan_ctrl #(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [W-1:0]        bid_in,
  output logic [N-1:0]        sel,
  output logic [(1<<N)-1:0]   grant,
  output logic                busy,
  output logic                done,
  output logic                valid,
  output logic [N-1:0]        winner,
  output logic [W-1:0]        win_bid,
  output logic [W-1:0]        price
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] SEL_LAST = {N{1'b1}};

  state_t state;

  // Round sequencing plus the running max / runner-up tracking; win_bid and
  // price double as the max and second registers so the results need no copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sel     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
      winner  <= '0;
      win_bid <= '0;
      price   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            win_bid <= '0;
            price   <= '0;
            winner  <= '0;
            valid   <= 1'b0;
            sel     <= '0;
            busy    <= 1'b1;
            state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Strict compare: an equal bid at a later index only raises price.
          if (bid_in > win_bid) begin
            price   <= win_bid;
            win_bid <= bid_in;
            winner  <= sel;
          end else if (bid_in > price) begin
            price <= bid_in;
          end
          if (sel == SEL_LAST) begin
            // valid rises together with the DONE cycle so both are seen at once;
            // sel stays parked on the last index.
            busy  <= 1'b0;
            done  <= 1'b1;
            valid <= 1'b1;
            state <= ST_DONE;
          end else begin
            sel <= sel + N'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // One-hot bidder grant, decoded from registered state and index only.
  always_comb begin
    grant = '0;
    if (state == ST_SCAN) grant[sel] = 1'b1;
  end

endmodule

// File: tb/tb_vickrey_scan_ctrl.sv
// Testbench for vickrey_scan_ctrl: randomized and directed auction rounds,
// a sorted-list reference model and a negedge monitor that checks every cycle.
module tb_vickrey_scan_ctrl;
  localparam int N  = 2;
  localparam int W  = 8;
  localparam int NB = 1 << N;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [W-1:0]    bid_in;
  logic [N-1:0]    sel;
  logic [NB-1:0]   grant;
  logic            busy, done, valid;
  logic [N-1:0]    winner;
  logic [W-1:0]    win_bid, price;

  logic [W-1:0]    bids [NB];

  typedef struct {
    int          k;
    int unsigned winner;
    int unsigned win_bid;
    int unsigned price;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  vickrey_scan_ctrl #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bid_in(bid_in),
    .sel(sel), .grant(grant), .busy(busy), .done(done), .valid(valid),
    .winner(winner), .win_bid(win_bid), .price(price)
  );

  // Combinational bid-select mux.
  assign bid_in = bids[sel];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: sort bids descending; price is the second entry, winner is the
  // lowest index holding the top value.
  function automatic exp_t model(input int k);
    exp_t e;
    int q[$];
    for (int i = 0; i < NB; i++) q.push_back(int'(bids[i]));
    q.rsort();
    e.k       = k;
    e.win_bid = q[0];
    e.price   = q[1];
    e.winner  = 0;
    for (int i = NB - 1; i >= 0; i--)
      if (int'(bids[i]) == q[0]) e.winner = i;
    return e;
  endfunction

  task automatic set_bids(input int b0, input int b1, input int b2, input int b3);
    bids[0] = W'(b0); bids[1] = W'(b1); bids[2] = W'(b2); bids[3] = W'(b3);
  endtask

  task automatic rand_bids();
    int mode;
    int same;
    mode = $urandom_range(0, 3);
    same = $urandom_range(0, 255);
    for (int i = 0; i < NB; i++) begin
      case (mode)
        0:       bids[i] = W'($urandom_range(0, 255));
        1:       bids[i] = W'($urandom_range(0, 3));
        2:       bids[i] = W'(same);
        default: bids[i] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
      endcase
    end
  endtask

  // Monitor: expected cycle-by-cycle behaviour derived from the cycle at which
  // the front scoreboard entry's start was accepted.
  int   mon_ph;
  bit   exp_valid = 1'b0;
  int   exp_sel = 0;
  exp_t last = '{default: 0};

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_valid = 1'b0;
      exp_sel   = 0;
      last      = '{default: 0};
    end else begin
      mon_ph = (sb.size() > 0) ? (cyc - sb[0].k) : -1;
      if (mon_ph >= 0 && mon_ph < NB) begin
        exp_sel   = mon_ph;
        exp_valid = 1'b0;
        chk("busy_scan", busy, 1);
        chk("done_scan", done, 0);
        chk("sel_scan", sel, exp_sel);
        chk("grant_scan", grant, 32'(1) << mon_ph);
        chk("valid_scan", valid, 0);
      end else begin
        if (mon_ph == NB) begin
          last      = sb.pop_front();
          exp_valid = 1'b1;
          chk("done_pulse", done, 1);
        end else begin
          chk("done_idle", done, 0);
        end
        chk("busy_idle", busy, 0);
        chk("grant_idle", grant, 0);
        chk("sel_hold", sel, exp_sel);
        chk("valid", valid, exp_valid);
        chk("winner", winner, last.winner);
        chk("win_bid", win_bid, last.win_bid);
        chk("price", price, last.price);
      end
    end
  end

  // One round; inject=1 adds ignored start pulses in SCAN and DONE.
  task automatic round(input bit inject);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(cyc));
    start = 1'b0;
    for (int p = 0; p <= NB; p++) begin
      @(negedge clk);
      start = inject && (p == 1 || p == NB);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // start held high: a new round is accepted every NB+2 cycles.
  task automatic held(input int rounds);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(cyc));
    for (int r = 1; r < rounds; r++) begin
      repeat (NB + 1) @(negedge clk);
      rand_bids();
      repeat (2) @(posedge clk);
      #1;
      sb.push_back(model(cyc));
    end
    start = 1'b0;
    repeat (NB + 2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_winner"}, winner, 0);
    chk({tag, "_win_bid"}, win_bid, 0);
    chk({tag, "_price"}, price, 0);
  endtask

  initial begin
    set_bids(0, 0, 0, 0);
    #12;
    check_zero("rst0");
    #6;
    rst_n = 1'b1;

    set_bids(5, 9, 3, 7);     round(1'b0);
    set_bids(4, 8, 8, 2);     round(1'b0);
    set_bids(8, 8, 8, 8);     round(1'b0);
    set_bids(0, 0, 0, 0);     round(1'b0);
    set_bids(255, 0, 0, 0);   round(1'b0);
    set_bids(6, 200, 200, 1); round(1'b1);
    repeat (3) @(negedge clk);

    set_bids(9, 1, 2, 3);
    held(3);

    // Reset in the third cycle of a scan.
    set_bids(10, 20, 30, 40);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(cyc));
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    set_bids(1, 2, 3, 4);
    round(1'b0);

    for (int i = 0; i < 30; i++) begin
      rand_bids();
      round(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vickrey_scan_ctrl.md
# vickrey_scan_ctrl

Sequential controller that runs one sealed-bid second-price (Vickrey) auction round over 2**N bidders. It sweeps the bidder index that drives the shared bid-select multiplexer and samples the selected bid each cycle. It tracks the highest bid, the winner index and the second-highest bid, then reports the winner and the price after a fixed-length scan. It sits between the auction top level, which issues `start` and consumes results, and the combinational bid-select/decode primitives, which it sequences.

## Interface

Parameters:
- N, 3, log2 of bidder count; the scan covers indices 0..2**N-1.
- W, 8, bid width in bits; bids are unsigned.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new auction round; honoured only in IDLE.
- bid_in  in  W  bid of the currently selected bidder; combinational return from the bid-select mux driven by `sel`.
- sel  out  N  binary bidder index; bit N-1 is the MSB.
- grant  out  2**N  one-hot of `sel` while in SCAN; all zeros otherwise.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse in DONE.
- valid  out  1  results valid; set in DONE, cleared on the next accepted `start` or on reset.
- winner  out  N  index of the highest bidder.
- win_bid  out  W  highest bid.
- price  out  W  second-highest bid, i.e. the price paid.

## Operation

- States:
  - IDLE: waits for `start`.
  - SCAN: one bidder per cycle.
  - DONE: one cycle, then returns to IDLE.
- IDLE, `start`=1:
  - Clear max, second and winner to 0; clear `valid`; set `sel`=0.
  - Go to SCAN.
- IDLE, `start`=0: hold all outputs.
- SCAN, each cycle, with bid b = `bid_in` at index `sel`:
  - If b > max: second <= max; max <= b; winner <= sel.
  - Else if b > second: second <= b.
  - The comparison is strict, so on a tie with max the lower index keeps the win and `price` equals the tied value.
- SCAN, `sel` = 2**N-1: after this cycle's update, go to DONE. Otherwise `sel` <= `sel`+1.
- `sel` never wraps within a round; it is held at its last value outside SCAN.
- DONE:
  - `done`=1 and `valid` <= 1; next state IDLE.
  - A `start` asserted in DONE is ignored.
- `start` in SCAN or DONE is ignored. There is no queuing.
- Results (`winner`, `win_bid`=max, `price`=second) are held from DONE until the next accepted `start`.
- Arithmetic: W-bit unsigned compares only, no addition, so no overflow is possible.
- All outputs are registered, or decoded from registered state only (`grant`, `busy`, `done`). There are no combinational paths from inputs to outputs.

## Timing

- Cycle 0: `start` sampled in IDLE.
- Cycles 1..2**N: SCAN; `sel` = cycle-1, `busy`=1.
- `bid_in` must be stable before the clock edge in the same cycle as `sel`; the mux is combinational, so there is zero-cycle return.
- Cycle 2**N+1: DONE, `done`=1. `winner`, `win_bid`, `price` and `valid` are visible from this cycle.
- Cycle 2**N+2: IDLE. The earliest next accepted `start` falls here, giving a round period of 2**N+2 cycles.
- Reset (asynchronous, any state including mid-SCAN):
  - State goes to IDLE.
  - `sel`=0, `grant`=0, `busy`=0, `done`=0, `valid`=0, `winner`=0, `win_bid`=0, `price`=0.
  - The partial round is discarded.
  - The first `start` is accepted on the first rising edge after `rst_n` deasserts.

## Test plan

- N=2, W=8, bids [5,9,3,7], `start` at cycle 0 -> `sel` 0,1,2,3 on cycles 1-4; `done` at cycle 5; `winner`=1, `win_bid`=9, `price`=7, `valid`=1.
- Tie, bids [4,8,8,2] -> `winner`=1, `win_bid`=8, `price`=8. Bids [8,8,8,8] -> `winner`=0, `price`=8.
- All-zero bids -> `winner`=0, `win_bid`=0, `price`=0, `valid`=1; max-value bids [255,0,0,0] -> `winner`=0, `price`=0.
- `start` held high continuously -> rounds accepted every 6 cycles (N=2). `start` pulses at cycles 2 and 5 (SCAN, DONE) are ignored; results stay stable until the next accepted `start`, then `valid`=0.
- `rst_n` low during cycle 3 of SCAN -> all outputs 0 immediately and state IDLE. A new round with bids [1,2,3,4] then gives `winner`=3, `price`=3.
- `grant` check -> `grant` equals 1<<`sel` throughout SCAN and is 0 in IDLE and DONE.
